fetch_unit: RTL
===============

// Module: fetch_unit
// PURPOSE
//  Instruction-fetch stage directly upstream of the synchronous PROM and the control unit.
//  Owns the fetch PC and drives prom_addr. Tags each PROM output word with its address and a valid bit.
//  Applies branch/call/return redirects with one squashed bubble.
//  Holds a hardware return-address stack and supplies the return address to the wb_mux pc input.
// PARAMETERS
//  ADDR_W        16       instruction address width (PROM word address)
//  STACK_DEPTH   16       return-stack entries (power of 2, >=2)
//  RESET_VECTOR  16'h0000 first fetch address; also the target of a return on an empty stack
// PORTS
//  clk             in   1       rising-edge clock
//  reset_n         in   1       one clock; reset is synchronous and active-low
//  stall           in   1       freeze fetch (CU/hazard)
//  branch_taken    in   1       redirect to branch_target; qualifies the current instruction
//  branch_target   in   ADDR_W  redirect / call destination
//  call            in   1       push ret_addr, redirect to branch_target
//  ret             in   1       pop stack, redirect to popped address
//  prom_addr       out  ADDR_W  fetch PC to PROM (PROM registers it; data valid 1 cycle later)
//  pc_out          out  ADDR_W  address of the instruction now on the PROM output
//  ret_addr        out  ADDR_W  pc_out+1 (mod 2^ADDR_W); feeds wb_mux pc input
//  inst_valid      out  1       PROM output word is a real, non-squashed instruction
//  stack_overflow  out  1       sticky: call with stack full
//  stack_underflow out  1       sticky: ret with stack empty
// BEHAVIOUR
//  Reset (reset_n=0 at edge, overrides everything, including mid-redirect):
//   - fpc=RESET_VECTOR, pc_out=RESET_VECTOR, inst_valid=0, sp=0, both sticky flags=0
//   - stack RAM contents are not cleared
//  prom_addr = fpc, combinational from the register.
//  FSM (state_t): S_BOOT -> S_RUN after 1 cycle out of reset; S_RUN -> S_BUBBLE on a redirect;
//   S_BUBBLE -> S_RUN next cycle. inst_valid=1 only in S_RUN.
//  Unstalled cycle, no redirect:
//   - pc_out<=fpc, fpc<=fpc+1, wrapping 16'hFFFF->16'h0000
//  Redirect:
//   - Controls are sampled only when inst_valid=1 && !stall; otherwise they are ignored.
//   - Priority ret > call > branch_taken; only one action per cycle.
//   - fpc<=target; pc_out<=fpc (stale); next state S_BUBBLE, so the sequentially fetched word is squashed.
//   - Redirect-to-valid-target latency: 2 cycles (1 bubble).
//  call:
//   - push ret_addr, then sp++; target=branch_target.
//   - If sp==STACK_DEPTH: no push, sp unchanged, stack_overflow<=1, redirect still happens.
//  ret:
//   - sp--, target=stack[sp-1].
//   - If sp==0: target=RESET_VECTOR, sp unchanged, stack_underflow<=1.
//  sp range 0..STACK_DEPTH (width $clog2(STACK_DEPTH)+1); never wraps.
//  stall=1: fpc, pc_out, inst_valid, state, sp and flags all hold. prom_addr is unchanged, so the PROM re-presents the same word.
//  Stall in S_BUBBLE holds the bubble; the bubble completes on the first unstalled cycle.
//  Sticky flags clear only on reset.
// STRUCTURE
//  eyearch_pkg:
//   - ADDR_W default
//   - state_t {S_BOOT, S_RUN, S_BUBBLE}
//   - redir_t {REDIR_NONE, REDIR_BR, REDIR_CALL, REDIR_RET}
//   - RESET_VECTOR default
//  Sub-module return_stack:
//   - parameters DEPTH, W
//   - ports clk, reset_n, push, pop, d_in, top, full, empty
//   - registered array plus sp, synchronous write, combinational top
//  fetch_unit keeps fpc/pc_out/FSM, redirect priority encode (redir_t), and flag logic.
// TESTING
//  1. Reset then free-run:
//     - Release reset_n at cycle 0: prom_addr 0,1,2,3...
//     - inst_valid 0 in the first cycle, then 1; pc_out lags prom_addr by 1.
//  2. Branch: branch_taken=1, target=16'h0040 while pc_out=5 valid.
//     - Next cycle inst_valid=0, prom_addr=0x40.
//     - Following cycle pc_out=0x40, inst_valid=1.
//  3. Call/return:
//     - Call at pc_out=0x10 to 0x80: ret_addr 0x11 pushed, execution resumes at 0x80.
//     - ret at 0x85: prom_addr=0x11 after a 1-cycle bubble; sp returns to 0.
//  4. Overflow/underflow with STACK_DEPTH=16:
//     - 17 nested calls: stack_overflow=1, sp stays 16.
//     - 17 returns: 17th goes to 0x0000, stack_underflow=1.
//  5. Stall and priority:
//     - stall for 3 cycles: prom_addr, pc_out, inst_valid held, with branch_taken=1 ignored throughout.
//     - ret+call+branch_taken together: ret wins, no push.
//  6. Wrap and mid-op reset:
//     - Fetch across 0xFFFF: next fetch is 0x0000, and ret_addr at pc_out=0xFFFF is 0x0000.
//     - reset_n=0 during S_BUBBLE: all outputs at reset values next cycle.

Source files
------------

// File: rtl/eyearch_pkg.sv
// Shared types and defaults for the instruction-fetch slice.
package eyearch_pkg;

  localparam int              DEF_ADDR_W       = 16;
  localparam int              DEF_STACK_DEPTH  = 16;
  localparam logic [15:0]     DEF_RESET_VECTOR = 16'h0000;

  typedef enum logic [1:0] {
    S_BOOT   = 2'd0,
    S_RUN    = 2'd1,
    S_BUBBLE = 2'd2
  } state_t;

  typedef enum logic [1:0] {
    REDIR_NONE = 2'd0,
    REDIR_BR   = 2'd1,
    REDIR_CALL = 2'd2,
    REDIR_RET  = 2'd3
  } redir_t;

endpackage

// File: rtl/fetch_unit_return_stack.sv
// Hardware return-address stack: registered array plus stack pointer,
// synchronous push/pop, combinational top-of-stack.
module return_stack #(
  parameter int DEPTH = 16,
  parameter int W     = 16
) (
  input  logic         clk,
  input  logic         reset_n,
  input  logic         push,
  input  logic         pop,
  input  logic [W-1:0] d_in,
  output logic [W-1:0] top,
  output logic         full,
  output logic         empty
);

  localparam int IDX_W = $clog2(DEPTH);
  localparam int SP_W  = IDX_W + 1;

  logic [W-1:0]     mem_q [DEPTH];
  logic [SP_W-1:0]  sp_q;
  logic [IDX_W-1:0] top_idx_s;

  assign full      = (sp_q == SP_W'(DEPTH));
  assign empty     = (sp_q == {SP_W{1'b0}});
  assign top_idx_s = sp_q[IDX_W-1:0] - IDX_W'(1);
  assign top       = mem_q[top_idx_s];

  // Stack pointer: saturates at 0 and DEPTH, cleared by reset.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      sp_q <= {SP_W{1'b0}};
    end else if (push && !full) begin
      sp_q <= sp_q + SP_W'(1);
    end else if (pop && !empty) begin
      sp_q <= sp_q - SP_W'(1);
    end else begin
      sp_q <= sp_q;
    end
  end

  // Entry storage: written on push, deliberately not cleared by reset.
  always_ff @(posedge clk) begin
    if (reset_n && push && !full) begin
      mem_q[sp_q[IDX_W-1:0]] <= d_in;
    end
  end

endmodule

// File: rtl/fetch_unit.sv
// Instruction-fetch stage: owns the fetch PC, tags PROM output words with
// address and valid, applies redirects with one squashed bubble, and keeps
// the return-address stack plus its sticky overflow/underflow flags.
module fetch_unit
  import eyearch_pkg::*;
#(
  parameter int                ADDR_W       = DEF_ADDR_W,
  parameter int                STACK_DEPTH  = DEF_STACK_DEPTH,
  parameter logic [ADDR_W-1:0] RESET_VECTOR = ADDR_W'(DEF_RESET_VECTOR)
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              stall,
  input  logic              branch_taken,
  input  logic [ADDR_W-1:0] branch_target,
  input  logic              call,
  input  logic              ret,
  output logic [ADDR_W-1:0] prom_addr,
  output logic [ADDR_W-1:0] pc_out,
  output logic [ADDR_W-1:0] ret_addr,
  output logic              inst_valid,
  output logic              stack_overflow,
  output logic              stack_underflow
);

  state_t            state_q;
  logic [ADDR_W-1:0] fpc_q;
  logic [ADDR_W-1:0] pc_out_q;
  logic              inst_valid_q;
  logic              ovf_q;
  logic              unf_q;

  redir_t            redir_s;
  logic [ADDR_W-1:0] target_s;
  logic              act_s;
  logic              push_s;
  logic              pop_s;
  logic [ADDR_W-1:0] stk_top_s;
  logic              stk_full_s;
  logic              stk_empty_s;

  assign prom_addr       = fpc_q;
  assign pc_out          = pc_out_q;
  assign ret_addr        = pc_out_q + ADDR_W'(1);
  assign inst_valid      = inst_valid_q;
  assign stack_overflow  = ovf_q;
  assign stack_underflow = unf_q;

  // Controls only qualify a real, unstalled instruction.
  assign act_s  = inst_valid_q && !stall;
  assign push_s = reset_n && (redir_s == REDIR_CALL) && !stk_full_s;
  assign pop_s  = reset_n && (redir_s == REDIR_RET) && !stk_empty_s;

  // Redirect priority encode (ret > call > branch) and target selection.
  always_comb begin
    redir_s  = REDIR_NONE;
    target_s = fpc_q;
    if (act_s) begin
      if (ret) begin
        redir_s  = REDIR_RET;
        target_s = stk_empty_s ? RESET_VECTOR : stk_top_s;
      end else if (call) begin
        redir_s  = REDIR_CALL;
        target_s = branch_target;
      end else if (branch_taken) begin
        redir_s  = REDIR_BR;
        target_s = branch_target;
      end else begin
        redir_s  = REDIR_NONE;
        target_s = fpc_q;
      end
    end else begin
      redir_s  = REDIR_NONE;
      target_s = fpc_q;
    end
  end

  return_stack #(
    .DEPTH (STACK_DEPTH),
    .W     (ADDR_W)
  ) u_return_stack (
    .clk     (clk),
    .reset_n (reset_n),
    .push    (push_s),
    .pop     (pop_s),
    .d_in    (ret_addr),
    .top     (stk_top_s),
    .full    (stk_full_s),
    .empty   (stk_empty_s)
  );

  // Fetch FSM: advances the PC, inserts one squashed bubble per redirect.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q      <= S_BOOT;
      fpc_q        <= RESET_VECTOR;
      pc_out_q     <= RESET_VECTOR;
      inst_valid_q <= 1'b0;
    end else if (stall) begin
      state_q      <= state_q;
      fpc_q        <= fpc_q;
      pc_out_q     <= pc_out_q;
      inst_valid_q <= inst_valid_q;
    end else begin
      case (state_q)
        S_RUN: begin
          pc_out_q <= fpc_q;
          if (redir_s != REDIR_NONE) begin
            fpc_q        <= target_s;
            state_q      <= S_BUBBLE;
            inst_valid_q <= 1'b0;
          end else begin
            fpc_q        <= fpc_q + ADDR_W'(1);
            state_q      <= S_RUN;
            inst_valid_q <= 1'b1;
          end
        end
        S_BOOT, S_BUBBLE: begin
          pc_out_q     <= fpc_q;
          fpc_q        <= fpc_q + ADDR_W'(1);
          state_q      <= S_RUN;
          inst_valid_q <= 1'b1;
        end
        default: begin
          state_q      <= S_BOOT;
          fpc_q        <= RESET_VECTOR;
          pc_out_q     <= RESET_VECTOR;
          inst_valid_q <= 1'b0;
        end
      endcase
    end
  end

  // Sticky stack-error flags, cleared only by reset.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      ovf_q <= 1'b0;
      unf_q <= 1'b0;
    end else begin
      ovf_q <= ovf_q | ((redir_s == REDIR_CALL) && stk_full_s);
      unf_q <= unf_q | ((redir_s == REDIR_RET) && stk_empty_s);
    end
  end

endmodule
